// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: six-digit keypad entry controller.
// Turns decoded key strobes into a six-nibble display buffer (blank = 4'hF)
// and latches the completed code on ENTER.
// Optional macro KEY_ENTRY_TIMEOUT_EN compiles in an idle timeout that
// abandons a stale entry after TIMEOUT_CYCLES cycles without a key.
module key_entry_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        press_valid,
    input  logic [3:0]  scan_code,
    output logic [23:0] display_code,
    output logic [2:0]  digit_count,
    output logic        entry_valid,
    output logic [23:0] entry_code,
    output logic        timeout
);

    typedef enum logic [1:0] {
        EMPTY,
        ENTRY,
        FULL,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_DIGIT,
        KEY_ENTER,
        KEY_BACK,
        KEY_CLEAR
    } key_t;

    localparam logic [23:0] BLANK = '1;

    state_t state;
    key_t   key;
    logic   timeout_hit;

    // Classify the current strobe; codes D..F and idle cycles map to KEY_NONE
    always_comb begin
        key = KEY_NONE;
        if (press_valid) begin
            if (scan_code <= 4'h9) begin
                key = KEY_DIGIT;
            end else begin
                case (scan_code)
                    4'hA:    key = KEY_ENTER;
                    4'hB:    key = KEY_BACK;
                    4'hC:    key = KEY_CLEAR;
                    default: key = KEY_NONE;
                endcase
            end
        end
    end

`ifdef KEY_ENTRY_TIMEOUT_EN
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             timeout_q;

    // Any strobe, even an ignored code, beats a timeout due in the same cycle
    assign timeout_hit = !press_valid && (state != EMPTY) && (idle_cnt == IDLE_LAST);
    assign timeout     = timeout_q;

    // Idle counter: cleared by any key, held at zero while nothing is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (press_valid || (state == EMPTY) || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
    assign unused_cfg  = ^{TIMEOUT_CYCLES, CNT_W};
`endif

    // Entry state machine with registered display, count and accept outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            display_code <= BLANK;
            digit_count  <= '0;
            entry_code   <= BLANK;
            entry_valid  <= 1'b0;
        end else begin
            entry_valid <= 1'b0;
            if (timeout_hit) begin
                state        <= EMPTY;
                display_code <= BLANK;
                digit_count  <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (key == KEY_DIGIT) begin
                            display_code <= {display_code[19:0], scan_code};
                            digit_count  <= 3'd1;
                            state        <= ENTRY;
                        end
                    end

                    ENTRY: begin
                        case (key)
                            KEY_DIGIT: begin
                                display_code <= {display_code[19:0], scan_code};
                                digit_count  <= digit_count + 3'd1;
                                if (digit_count == 3'd5) begin
                                    state <= FULL;
                                end
                            end
                            KEY_BACK: begin
                                display_code <= {4'hF, display_code[23:4]};
                                digit_count  <= digit_count - 3'd1;
                                if (digit_count == 3'd1) begin
                                    state <= EMPTY;
                                end
                            end
                            KEY_CLEAR: begin
                                display_code <= BLANK;
                                digit_count  <= '0;
                                state        <= EMPTY;
                            end
                            KEY_ENTER: begin
                                entry_code  <= display_code;
                                entry_valid <= 1'b1;
                                state       <= DONE;
                            end
                            default: ;
                        endcase
                    end

                    FULL: begin
                        // Further digits are dropped so the oldest digit is never lost
                        case (key)
                            KEY_BACK: begin
                                display_code <= {4'hF, display_code[23:4]};
                                digit_count  <= 3'd5;
                                state        <= ENTRY;
                            end
                            KEY_CLEAR: begin
                                display_code <= BLANK;
                                digit_count  <= '0;
                                state        <= EMPTY;
                            end
                            KEY_ENTER: begin
                                entry_code  <= display_code;
                                entry_valid <= 1'b1;
                                state       <= DONE;
                            end
                            default: ;
                        endcase
                    end

                    DONE: begin
                        // Display stays frozen on the accepted code until the next key
                        case (key)
                            KEY_DIGIT: begin
                                display_code <= {20'hFFFFF, scan_code};
                                digit_count  <= 3'd1;
                                state        <= ENTRY;
                            end
                            KEY_BACK, KEY_CLEAR: begin
                                display_code <= BLANK;
                                digit_count  <= '0;
                                state        <= EMPTY;
                            end
                            default: ;
                        endcase
                    end

                    default: begin
                        state        <= EMPTY;
                        display_code <= BLANK;
                        digit_count  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// tb_key_entry_ctrl: table-driven directed bench for key_entry_ctrl.
// With KEY_ENTRY_TIMEOUT_EN defined, the timeout sequences run with
// TIMEOUT_CYCLES = 8; otherwise the bench checks that entries persist.
module tb_key_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        press_valid = 1'b0;
    logic [3:0]  scan_code = 4'h0;
    logic [23:0] display_code;
    logic [2:0]  digit_count;
    logic        entry_valid;
    logic [23:0] entry_code;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_entry_ctrl #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .press_valid(press_valid),
        .scan_code(scan_code),
        .display_code(display_code),
        .digit_count(digit_count),
        .entry_valid(entry_valid),
        .entry_code(entry_code),
        .timeout(timeout)
    );

    typedef struct {
        logic        r;
        logic        pv;
        logic [3:0]  code;
        logic [23:0] disp;
        logic [2:0]  cnt;
        logic        ev;
        logic [23:0] ecode;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic pv, input logic [3:0] code,
                       input logic [23:0] disp, input logic [2:0] cnt,
                       input logic ev, input logic [23:0] ecode);
        vec_t v;
        v.r = r; v.pv = pv; v.code = code;
        v.disp = disp; v.cnt = cnt; v.ev = ev; v.ecode = ecode;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic pv, input logic [3:0] code);
        @(negedge clk);
        rst = r;
        press_valid = pv;
        scan_code = code;
        @(posedge clk);
        #1;
        rst = 1'b0;
        press_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic [23:0] d, input logic [2:0] c,
                         input logic ev, input logic [23:0] ec, input logic to);
        checks++;
        if ({display_code, digit_count, entry_valid, entry_code, timeout} !== {d, c, ev, ec, to}) begin
            errors++;
            $display("FAIL %s: got disp=%h cnt=%0d ev=%b code=%h to=%b, want disp=%h cnt=%0d ev=%b code=%h to=%b",
                     name, display_code, digit_count, entry_valid, entry_code, timeout,
                     d, c, ev, ec, to);
        end
    endtask

    initial begin
        // reset
        add(1, 0, 4'h0, 24'hFFFFFF, 0, 0, 24'hFFFFFF);
        // keys 1,2,3 then clear
        add(0, 1, 4'h1, 24'hFFFFF1, 1, 0, 24'hFFFFFF);
        add(0, 1, 4'h2, 24'hFFFF12, 2, 0, 24'hFFFFFF);
        add(0, 1, 4'h3, 24'hFFF123, 3, 0, 24'hFFFFFF);
        add(0, 1, 4'hC, 24'hFFFFFF, 0, 0, 24'hFFFFFF);
        // keys 1..7 (7 dropped when full), backspace, enter, idle, clear from DONE
        add(0, 1, 4'h1, 24'hFFFFF1, 1, 0, 24'hFFFFFF);
        add(0, 1, 4'h2, 24'hFFFF12, 2, 0, 24'hFFFFFF);
        add(0, 1, 4'h3, 24'hFFF123, 3, 0, 24'hFFFFFF);
        add(0, 1, 4'h4, 24'hFF1234, 4, 0, 24'hFFFFFF);
        add(0, 1, 4'h5, 24'hF12345, 5, 0, 24'hFFFFFF);
        add(0, 1, 4'h6, 24'h123456, 6, 0, 24'hFFFFFF);
        add(0, 1, 4'h7, 24'h123456, 6, 0, 24'hFFFFFF);
        add(0, 1, 4'hB, 24'hF12345, 5, 0, 24'hFFFFFF);
        add(0, 1, 4'hA, 24'hF12345, 5, 1, 24'hF12345);
        add(0, 0, 4'h0, 24'hF12345, 5, 0, 24'hF12345);
        add(0, 1, 4'hC, 24'hFFFFFF, 0, 0, 24'hF12345);
        // keys 4,2,A,A,9 then backspace from one digit
        add(0, 1, 4'h4, 24'hFFFFF4, 1, 0, 24'hF12345);
        add(0, 1, 4'h2, 24'hFFFF42, 2, 0, 24'hF12345);
        add(0, 1, 4'hA, 24'hFFFF42, 2, 1, 24'hFFFF42);
        add(0, 1, 4'hA, 24'hFFFF42, 2, 0, 24'hFFFF42);
        add(0, 1, 4'h9, 24'hFFFFF9, 1, 0, 24'hFFFF42);
        add(0, 1, 4'hB, 24'hFFFFFF, 0, 0, 24'hFFFF42);
        // keys 5,B,B,A: back to EMPTY, then ignored
        add(0, 1, 4'h5, 24'hFFFFF5, 1, 0, 24'hFFFF42);
        add(0, 1, 4'hB, 24'hFFFFFF, 0, 0, 24'hFFFF42);
        add(0, 1, 4'hB, 24'hFFFFFF, 0, 0, 24'hFFFF42);
        add(0, 1, 4'hA, 24'hFFFFFF, 0, 0, 24'hFFFF42);
        // ignored codes D..F
        add(0, 1, 4'hD, 24'hFFFFFF, 0, 0, 24'hFFFF42);
        add(0, 1, 4'h7, 24'hFFFFF7, 1, 0, 24'hFFFF42);
        add(0, 1, 4'hE, 24'hFFFFF7, 1, 0, 24'hFFFF42);
        add(0, 1, 4'hF, 24'hFFFFF7, 1, 0, 24'hFFFF42);
        add(0, 1, 4'h8, 24'hFFFF78, 2, 0, 24'hFFFF42);
        add(0, 1, 4'hC, 24'hFFFFFF, 0, 0, 24'hFFFF42);
        // enter from FULL, then new digit from DONE
        add(0, 1, 4'h9, 24'hFFFFF9, 1, 0, 24'hFFFF42);
        add(0, 1, 4'h8, 24'hFFFF98, 2, 0, 24'hFFFF42);
        add(0, 1, 4'h7, 24'hFFF987, 3, 0, 24'hFFFF42);
        add(0, 1, 4'h6, 24'hFF9876, 4, 0, 24'hFFFF42);
        add(0, 1, 4'h5, 24'hF98765, 5, 0, 24'hFFFF42);
        add(0, 1, 4'h4, 24'h987654, 6, 0, 24'hFFFF42);
        add(0, 1, 4'hA, 24'h987654, 6, 1, 24'h987654);
        add(0, 1, 4'h1, 24'hFFFFF1, 1, 0, 24'h987654);
        add(0, 1, 4'hB, 24'hFFFFFF, 0, 0, 24'h987654);
        // clear from FULL
        add(0, 1, 4'h1, 24'hFFFFF1, 1, 0, 24'h987654);
        add(0, 1, 4'h2, 24'hFFFF12, 2, 0, 24'h987654);
        add(0, 1, 4'h3, 24'hFFF123, 3, 0, 24'h987654);
        add(0, 1, 4'h4, 24'hFF1234, 4, 0, 24'h987654);
        add(0, 1, 4'h5, 24'hF12345, 5, 0, 24'h987654);
        add(0, 1, 4'h6, 24'h123456, 6, 0, 24'h987654);
        add(0, 1, 4'hC, 24'hFFFFFF, 0, 0, 24'h987654);
        // reset mid-entry at FF1234 (reset beats a simultaneous key)
        add(0, 1, 4'h1, 24'hFFFFF1, 1, 0, 24'h987654);
        add(0, 1, 4'h2, 24'hFFFF12, 2, 0, 24'h987654);
        add(0, 1, 4'h3, 24'hFFF123, 3, 0, 24'h987654);
        add(0, 1, 4'h4, 24'hFF1234, 4, 0, 24'h987654);
        add(1, 1, 4'h5, 24'hFFFFFF, 0, 0, 24'hFFFFFF);
        add(0, 1, 4'h8, 24'hFFFFF8, 1, 0, 24'hFFFFFF);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].pv, vecs[i].code);
            check($sformatf("vec%0d", i), vecs[i].disp, vecs[i].cnt, vecs[i].ev, vecs[i].ecode, 1'b0);
        end

        step(1, 0, 4'h0);
        check("reset2", 24'hFFFFFF, 0, 0, 24'hFFFFFF, 0);

`ifdef KEY_ENTRY_TIMEOUT_EN
        // key 3 then idle: pulse on the eighth idle edge
        step(0, 1, 4'h3);
        check("to_key", 24'hFFFFF3, 1, 0, 24'hFFFFFF, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 4'h0);
            if (i < 8) check($sformatf("to_idle%0d", i), 24'hFFFFF3, 1, 0, 24'hFFFFFF, 0);
            else       check("to_fire", 24'hFFFFFF, 0, 0, 24'hFFFFFF, 1);
        end
        step(0, 0, 4'h0);
        check("to_after", 24'hFFFFFF, 0, 0, 24'hFFFFFF, 0);

        // a key on the edge the timeout would fire wins
        step(0, 1, 4'h3);
        for (int i = 1; i <= 7; i++) begin
            step(0, 0, 4'h0);
            check($sformatf("sup_idle%0d", i), 24'hFFFFF3, 1, 0, 24'hFFFFFF, 0);
        end
        step(0, 1, 4'h4);
        check("sup_key", 24'hFFFF34, 2, 0, 24'hFFFFFF, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 4'h0);
            if (i < 8) check($sformatf("sup2_idle%0d", i), 24'hFFFF34, 2, 0, 24'hFFFFFF, 0);
            else       check("sup2_fire", 24'hFFFFFF, 0, 0, 24'hFFFFFF, 1);
        end
`else
        // without the timeout the entry persists
        step(0, 1, 4'h3);
        check("hold_key", 24'hFFFFF3, 1, 0, 24'hFFFFFF, 0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 4'h0);
            check($sformatf("hold_idle%0d", i), 24'hFFFFF3, 1, 0, 24'hFFFFFF, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
